// File: rtl/team_06_pkg.sv
// Shared constants and types for the team_06 button conditioner.
// Button indices, debounce state enum and default debounce length.
package team_06_pkg;

  localparam int BTN_PTT    = 0;
  localparam int BTN_EFFECT = 1;
  localparam int BTN_MUTE   = 2;
  localparam int BTN_NG     = 3;
  localparam int NUM_BTN    = 4;

  localparam int DEBOUNCE_CYCLES_DEF = 10000;

  typedef enum logic {
    STABLE_LO,
    STABLE_HI
  } db_state_e;

endpackage

// File: rtl/team_06_debounce.sv
// One-button conditioner: 2-flop synchroniser, counter, 2-state FSM.
// Ports: clk, rst (async, high), raw (async in), stable (level), rise.
module team_06_debounce
  import team_06_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  db_state_e        state_q;
  db_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= stable;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (s2_q != stable) begin
      if (cnt_q == CNT_MAX) begin
        unique case (state_q)
          STABLE_LO: state_d = STABLE_HI;
          STABLE_HI: state_d = STABLE_LO;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign stable = (state_q == STABLE_HI);
  // High for the one cycle after stable rises; the top registers it.
  assign rise   = stable & ~hi_q;

endmodule

// File: rtl/team_06_button_ctrl.sv
// Debounces four pushbuttons into FSM-ready ptt/effect/mute/ng controls.
// Ports: clk, rst, *_btn_raw in; ptt_en, effect, mute, ng_en, btn_state out.
module team_06_button_ctrl
  import team_06_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ptt_btn_raw,
  input  logic       effect_btn_raw,
  input  logic       mute_btn_raw,
  input  logic       ng_btn_raw,
  output logic       ptt_en,
  output logic       effect,
  output logic       mute,
  output logic       ng_en,
  output logic [3:0] btn_state
);

  logic [NUM_BTN-1:0] raw_w;
  logic [NUM_BTN-1:0] stable_w;
  logic [NUM_BTN-1:0] rise_w;
  logic               ptt_rise_unused;

  logic effect_q, effect_d;
  logic mute_q, mute_d;
  logic ng_q, ng_d;

  assign raw_w[BTN_PTT]    = ptt_btn_raw;
  assign raw_w[BTN_EFFECT] = effect_btn_raw;
  assign raw_w[BTN_MUTE]   = mute_btn_raw;
  assign raw_w[BTN_NG]     = ng_btn_raw;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    team_06_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_w[i]),
      .stable(stable_w[i]),
      .rise  (rise_w[i])
    );
  end

  // ptt is a pure level; its edge is not needed.
  assign ptt_rise_unused = rise_w[BTN_PTT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      effect_q <= 1'b0;
      mute_q   <= 1'b0;
      ng_q     <= 1'b0;
    end else begin
      effect_q <= effect_d;
      mute_q   <= mute_d;
      ng_q     <= ng_d;
    end
  end

  always_comb begin
    effect_d = rise_w[BTN_EFFECT];
    mute_d   = rise_w[BTN_MUTE];
    ng_d     = ng_q ^ rise_w[BTN_NG];
  end

  assign ptt_en    = stable_w[BTN_PTT];
  assign effect    = effect_q;
  assign mute      = mute_q;
  assign ng_en     = ng_q;
  assign btn_state = stable_w;

endmodule
